// File: rtl/imem_fetch_sync.sv
// Synchronous-read byte-addressed instruction memory with streaming byte loader.
// Define IMEM_ALIGN_CHECK_EN to fault on fetches with fetch_addr[1:0] != 0.
module imem_fetch_sync #(
  parameter int          ADDR_W      = 64,
  parameter int          DEPTH_BYTES = 128,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [31:0]       instruction,
  output logic              inst_fault,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_busy
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH_BYTES);
  localparam logic [AW-1:0]     LAST_PTR  = AW'(DEPTH_BYTES - 1);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t        r_state;
  logic [1:0]    r_idle_cnt;
  logic [AW-1:0] r_ptr;
  logic          r_valid;
  logic          r_fault;
  logic          r_busy;
  logic [31:0]   r_instr;
  logic [7:0]    r_mem [DEPTH_BYTES];

  logic          w_accept;
  logic          w_range_flt;
  logic          w_align_flt;
  logic          w_fault;
  logic          w_we;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_wnext;
  logic [AW-1:0] w_ra;
  logic [31:0]   w_rdata;

  assign fetch_ready = (r_state == S_IDLE) && !load_start;
  assign inst_valid  = r_valid;
  assign instruction = r_instr;
  assign inst_fault  = r_fault;
  assign load_busy   = r_busy;

  assign w_accept = fetch_req && fetch_ready;

  // load_start redirects the write pointer in the same cycle it is seen
  assign w_base  = AW'(load_base % DEPTH_A);
  assign w_waddr = load_start ? w_base : r_ptr;
  assign w_wnext = (w_waddr == LAST_PTR) ? '0 : w_waddr + 1'b1;
  assign w_we    = load_valid && (load_start || r_state == S_LOAD);

  assign w_range_flt = fetch_addr > LAST_ADDR;
`ifdef IMEM_ALIGN_CHECK_EN
  assign w_align_flt = |fetch_addr[1:0];
`else
  assign w_align_flt = 1'b0;
`endif
  assign w_fault = w_range_flt || w_align_flt;

  assign w_ra    = {fetch_addr[AW-1:2], 2'b00};
  assign w_rdata = {r_mem[w_ra + AW'(3)], r_mem[w_ra + AW'(2)],
                    r_mem[w_ra + AW'(1)], r_mem[w_ra]};

  always_ff @(posedge clk) begin
    if (!reset && w_we) begin
      r_mem[w_waddr] <= load_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= 2'd0;
      r_ptr      <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_instr    <= NOP_WORD;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_fault <= w_fault;
        r_instr <= w_fault ? NOP_WORD : w_rdata;
      end
      unique case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_idle_cnt <= 2'd0;
            r_ptr      <= load_valid ? w_wnext : w_base;
          end
        end
        S_LOAD: begin
          if (load_start) begin
            r_idle_cnt <= 2'd0;
            r_ptr      <= load_valid ? w_wnext : w_base;
          end else if (load_valid) begin
            r_idle_cnt <= 2'd0;
            r_ptr      <= w_wnext;
          end else if (r_idle_cnt == 2'd1) begin
            // second consecutive quiet cycle ends the burst
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_idle_cnt <= 2'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_sync.sv
// Randomized self-checking bench for imem_fetch_sync against a byte-array model.
// Compile with the same IMEM_ALIGN_CHECK_EN setting as the RTL.
module tb_imem_fetch_sync;

  localparam int D = 128;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [63:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        inst_valid;
  logic [31:0] instruction;
  logic        inst_fault;
  logic        load_start = 1'b0;
  logic [63:0] load_base = '0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_busy;

  imem_fetch_sync dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .inst_valid(inst_valid),
    .instruction(instruction), .inst_fault(inst_fault),
    .load_start(load_start), .load_base(load_base),
    .load_valid(load_valid), .load_byte(load_byte),
    .load_busy(load_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mm [D];
  int          m_ptr = 0;
  int          m_idle = 0;
  bit          m_busy = 1'b0;
  bit          e_valid = 1'b0;
  bit          e_fault = 1'b0;
  bit          e_ready;
  bit          o_ready;
  logic [31:0] e_instr = NOP;

  // Drive one clock of inputs, predict the outcome from the rules, advance.
  task automatic cyc(input bit rst, input bit fr, input logic [63:0] fa,
                     input bit ls, input logic [63:0] lb,
                     input bit lv, input logic [7:0] by);
    int p;
    int a;
    reset = rst; fetch_req = fr; fetch_addr = fa;
    load_start = ls; load_base = lb; load_valid = lv; load_byte = by;
    #1;
    o_ready = fetch_ready;
    e_ready = !m_busy && !ls;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_idle = 0;
      e_valid = 0; e_fault = 0; e_instr = NOP;
    end else begin
      e_valid = fr && e_ready;
      if (e_valid) begin
        e_fault = (fa > 64'd124);
`ifdef IMEM_ALIGN_CHECK_EN
        if (fa[1:0] != 2'b00) e_fault = 1;
`endif
        if (e_fault) e_instr = NOP;
        else begin
          a = int'(fa[6:0]) & ~3;
          e_instr = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
        end
      end
      if (ls) begin
        p = int'(lb % 64'd128);
        if (lv) begin mm[p] = by; p = (p + 1) % D; end
        m_ptr = p; m_busy = 1; m_idle = 0;
      end else if (m_busy) begin
        if (lv) begin
          mm[m_ptr] = by; m_ptr = (m_ptr + 1) % D; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == 2) begin m_busy = 0; m_idle = 0; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 64'd0, 0, 0, 0, 8'h0);
    checks++; if (inst_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got=%0b exp=0", inst_valid); end
    checks++; if (inst_fault !== 1'b0) begin errors++;
      $display("FAIL rst_fault got=%0b exp=0", inst_fault); end
    checks++; if (instruction !== NOP) begin errors++;
      $display("FAIL rst_instr got=%h exp=%h", instruction, NOP); end
    checks++; if (load_busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy got=%0b exp=0", load_busy); end
    cyc(0, 0, 64'd0, 0, 0, 0, 8'h0);
    checks++; if (o_ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready got=%0b exp=1", o_ready); end
  endtask

  task automatic test_load_fetch();
    logic [7:0] b [4];
    b = '{8'h93, 8'h02, 8'h40, 8'h00};
    cyc(0, 0, 64'd0, 1, 64'd0, 0, 8'h0);
    checks++; if (o_ready !== 1'b0) begin errors++;
      $display("FAIL lf_ready_start got=%0b exp=0", o_ready); end
    checks++; if (load_busy !== 1'b1) begin errors++;
      $display("FAIL lf_busy got=%0b exp=1", load_busy); end
    for (int i = 0; i < 4; i++) cyc(0, 0, 64'd0, 0, 0, 1, b[i]);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 64'd0, 0, 0, 0, 8'h0);
      checks++; if (load_busy !== m_busy) begin errors++;
        $display("FAIL lf_busy_drain got=%0b exp=%0b", load_busy, m_busy); end
    end
    cyc(0, 1, 64'd0, 0, 0, 0, 8'h0);
    checks++; if (inst_valid !== 1'b1) begin errors++;
      $display("FAIL lf_valid got=%0b exp=1", inst_valid); end
    checks++; if (instruction !== 32'h00400293) begin errors++;
      $display("FAIL lf_instr got=%h exp=00400293", instruction); end
    checks++; if (inst_fault !== 1'b0) begin errors++;
      $display("FAIL lf_fault got=%0b exp=0", inst_fault); end
    cyc(0, 0, 64'd0, 0, 0, 0, 8'h0);
    checks++; if (inst_valid !== 1'b0 || instruction !== 32'h00400293) begin
      errors++; $display("FAIL lf_hold got=%0b/%h exp=0/00400293",
                         inst_valid, instruction); end
  endtask

  task automatic test_fill_random();
    cyc(0, 0, 64'd0, 1, 64'd0, 1, 8'($urandom));
    for (int i = 1; i < D; i++) cyc(0, 0, 64'd0, 0, 0, 1, 8'($urandom));
    cyc(0, 0, 64'd0, 0, 0, 0, 8'h0);
    cyc(0, 0, 64'd0, 0, 0, 0, 8'h0);
    checks++; if (load_busy !== 1'b0) begin errors++;
      $display("FAIL fill_busy got=%0b exp=0", load_busy); end
  endtask

  task automatic test_random_fetch();
    logic [63:0] fa;
    bit fr;
    bit lv;
    for (int i = 0; i < 80; i++) begin
      fr = ($urandom % 4) != 0;
      lv = ($urandom % 5) == 0;
      case ($urandom % 4)
        0: fa = 64'(($urandom % 32) * 4);
        1: fa = 64'($urandom % 128);
        2: fa = {32'($urandom), 32'($urandom)};
        default: fa = 64'(124 + ($urandom % 8));
      endcase
      cyc(0, fr, fa, 0, 0, lv, 8'($urandom));
      checks++; if (inst_valid !== e_valid) begin errors++;
        $display("FAIL rnd_valid a=%h got=%0b exp=%0b", fa, inst_valid, e_valid); end
      checks++; if (instruction !== e_instr) begin errors++;
        $display("FAIL rnd_instr a=%h got=%h exp=%h", fa, instruction, e_instr); end
      if (e_valid) begin
        checks++; if (inst_fault !== e_fault) begin errors++;
          $display("FAIL rnd_fault a=%h got=%0b exp=%0b", fa, inst_fault, e_fault); end
      end
    end
    checks++; if (load_busy !== 1'b0) begin errors++;
      $display("FAIL rnd_busy got=%0b exp=0", load_busy); end
  endtask

  task automatic test_boundary();
    logic [63:0] addrs [6];
    addrs = '{64'd124, 64'd125, 64'd128, 64'h1_0000_0000,
              64'h1_0000_007C, 64'hFFFF_FFFF_FFFF_FFFC};
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, addrs[i], 0, 0, 0, 8'h0);
      checks++; if (inst_valid !== 1'b1) begin errors++;
        $display("FAIL bnd_valid a=%h got=%0b exp=1", addrs[i], inst_valid); end
      checks++; if (inst_fault !== e_fault) begin errors++;
        $display("FAIL bnd_fault a=%h got=%0b exp=%0b", addrs[i], inst_fault, e_fault); end
      checks++; if (instruction !== e_instr) begin errors++;
        $display("FAIL bnd_instr a=%h got=%h exp=%h", addrs[i], instruction, e_instr); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b [4];
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cyc(0, 0, 64'd0, 1, 64'd382, 0, 8'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 64'd0, 0, 0, 1, b[i]);
    cyc(0, 0, 64'd0, 0, 0, 0, 8'h0);
    cyc(0, 0, 64'd0, 0, 0, 0, 8'h0);
    cyc(0, 1, 64'd124, 0, 0, 0, 8'h0);
    checks++; if (instruction[31:16] !== 16'hBBAA || instruction !== e_instr) begin
      errors++; $display("FAIL wrap_hi got=%h exp=%h", instruction, e_instr); end
    cyc(0, 1, 64'd0, 0, 0, 0, 8'h0);
    checks++; if (instruction[15:0] !== 16'hDDCC || instruction !== e_instr) begin
      errors++; $display("FAIL wrap_lo got=%h exp=%h", instruction, e_instr); end
  endtask

  task automatic test_fetch_during_load();
    int first;
    first = -1;
    cyc(0, 1, 64'd8, 1, 64'd40, 0, 8'h0);
    checks++; if (o_ready !== 1'b0) begin errors++;
      $display("FAIL fdl_ready_start got=%0b exp=0", o_ready); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 64'd8, 0, 0, 1, 8'($urandom));
      checks++; if (o_ready !== 1'b0 || inst_valid !== 1'b0) begin errors++;
        $display("FAIL fdl_blocked got=%0b/%0b exp=0/0", o_ready, inst_valid); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 64'd8, 0, 0, 0, 8'h0);
      if (first < 0 && o_ready) first = i;
      checks++; if (o_ready !== e_ready || inst_valid !== e_valid) begin errors++;
        $display("FAIL fdl_resume i=%0d got=%0b/%0b exp=%0b/%0b",
                 i, o_ready, inst_valid, e_ready, e_valid); end
    end
    checks++; if (first != 2) begin errors++;
      $display("FAIL fdl_gap got=%0d exp=2", first); end
    checks++; if (instruction !== e_instr) begin errors++;
      $display("FAIL fdl_instr got=%h exp=%h", instruction, e_instr); end
  endtask

  task automatic test_reset_midburst();
    cyc(0, 0, 64'd0, 1, 64'd4, 1, 8'h11);
    cyc(0, 0, 64'd0, 0, 0, 1, 8'h22);
    cyc(1, 0, 64'd0, 0, 0, 1, 8'h33);
    checks++; if (load_busy !== 1'b0) begin errors++;
      $display("FAIL rmb_busy got=%0b exp=0", load_busy); end
    cyc(0, 1, 64'd4, 0, 0, 0, 8'h0);
    checks++; if (instruction[15:0] !== 16'h2211 || instruction !== e_instr) begin
      errors++; $display("FAIL rmb_word got=%h exp=%h", instruction, e_instr); end
    cyc(0, 1, 64'd6, 0, 0, 0, 8'h0);
    checks++; if (inst_fault !== e_fault || instruction !== e_instr) begin errors++;
      $display("FAIL rmb_a6 got=%0b/%h exp=%0b/%h",
               inst_fault, instruction, e_fault, e_instr); end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_fill_random();
    test_random_fetch();
    test_boundary();
    test_wrap();
    test_fetch_during_load();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
